satalnk_rxprim: RTL and testbench
=================================

# satalnk_rxprim

Parametrised RX primitive filter for the SATA link layer. It runs in the `i_rx_clk` domain between the PHY receive stream and the RX clock-crossing FIFO. It strips ALIGN primitives and resolves CONT sequences, either by dropping the scrambled filler or by expanding it into repeats of the held primitive. It also flags illegal CONT usage and loss of ALIGN cadence, so the TX-domain link FSM receives a clean primitive/data stream.

## Interface
- `OPT_EXPAND`, default 1: 1 = each filler word after CONT is emitted as a repeat of the held primitive; 0 = filler is dropped.
- `LGALIGN`, default 8: log2 of the ALIGN watchdog limit, counted in valid input words.
- `P_ALIGN`, default ALIGN value from the shared package: ALIGN primitive code.
- `P_CONT`, default CONT value from the shared package: CONT primitive code.

- `i_rx_clk`  in  1  RX recovered clock.
- `i_reset`  in  1  reset, asynchronous, active-high; clock `i_rx_clk`.
- `i_valid`  in  1  input word valid. No ready: the block always accepts.
- `i_primitive`  in  1  input word is a primitive (K-coded).
- `i_data`  in  32  input word.
- `o_valid`  out  1  output word valid.
- `o_primitive`  out  1  output word is a primitive.
- `o_data`  out  32  output word.
- `o_cont_err`  out  1  one-cycle pulse: CONT received with no primitive held.
- `o_align_lost`  out  1  level: no ALIGN seen within 2^LGALIGN−1 valid words.
- `o_align_count`  out  16  ALIGNs received, saturating. Present only under `SATALNK_RXPRIM_STATS_EN`.
- `o_cont_count`  out  16  CONT sequences entered, saturating. Present only under `SATALNK_RXPRIM_STATS_EN`.

## Operation
- FSM states:
  - `IDLE`: no primitive held.
  - `PRIM`: primitive held, no continuation.
  - `CONT`: continuation active.
- Only cycles with `i_valid`=1 affect state; `i_valid`=0 holds all state and drives `o_valid`=0.
- ALIGN (`i_primitive`=1, `i_data`=`P_ALIGN`), in any state:
  - never forwarded;
  - no FSM change;
  - clears the watchdog.
- CONT primitive:
  - `PRIM` → `CONT`, not forwarded, `o_cont_count`+1;
  - `CONT` → `CONT`, no count;
  - `IDLE` → stays `IDLE`, `o_cont_err` pulses.
- Any other primitive, in any state: forwarded, latched into the hold register, → `PRIM`. This is the only exit from `CONT`.
- Data word (`i_primitive`=0):
  - in `CONT`: with `OPT_EXPAND`=1, output the held primitive (`o_primitive`=1); with `OPT_EXPAND`=0, output nothing;
  - in `IDLE`/`PRIM`: forward as data, → `IDLE`.
- Watchdog:
  - counts valid non-ALIGN words and saturates at 2^LGALIGN−1;
  - `o_align_lost`=1 while saturated;
  - cleared on the next ALIGN.
- Stats counters saturate at 16'hFFFF and never wrap.

## Timing
- All outputs are registered; latency is exactly 1 cycle from the input word to `o_valid`/`o_data`.
- Full throughput: one output per valid, non-suppressed input per cycle. No back-pressure exists; downstream must always sink.
- `o_cont_err` is asserted in the same cycle an output for that word would appear.
- Reset values:
  - `o_valid`, `o_primitive`, `o_data`, `o_cont_err`, `o_align_lost` = 0;
  - counters = 0;
  - FSM = `IDLE`;
  - hold register = 0;
  - watchdog = 0.
- Reset asserted mid-sequence: all state clears asynchronously. After release, the first CONT before any primitive is an error.
- ALIGN arriving on the same cycle the watchdog would saturate: the clear wins, and `o_align_lost` stays 0.

## Configuration
- `SATALNK_RXPRIM_STATS_EN` defined: `o_align_count`/`o_cont_count` ports and their counters exist.
- Undefined: the ports are absent and the counters are not built. All other behaviour is identical.

## Structure
- ALIGN/CONT/SYNC/HOLD codes come from the shared SATA primitives package. FSM state encoding also belongs there, for reuse by the link FSM assertions.
- One sub-module: `satalnk_alignwd` (the saturating ALIGN watchdog counter, parametrised by LGALIGN).

## Test plan
- X_RDY, CONT, 5 data, SYNC; `OPT_EXPAND`=1 → outputs X_RDY ×6, then SYNC, each 1 cycle after its input; `o_cont_count`=1.
- Same stimulus, `OPT_EXPAND`=0 → outputs X_RDY, SYNC only.
- Reset, then CONT → no output; `o_cont_err`=1 for exactly one cycle; FSM stays `IDLE`.
- `LGALIGN`=4: 15 valid data words with no ALIGN → `o_align_lost` rises; one ALIGN → falls next cycle with no output word.
- Interleaved `i_valid`=0 gaps and ALIGNs inside a CONT run → gaps produce no output; ALIGNs are removed; the expansion count equals the data-word count.
- Assert `i_reset` during `CONT`, release, then send data 32'h1234_5678 → forwarded as data; no expansion.

Source files
------------

// File: rtl/satalnk_rxprim_pkg.sv
// Shared SATA link-layer primitive codes and RX primitive filter state encoding.
// Also used by the link FSM assertions.
package satalnk_rxprim_pkg;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_CONT  = 32'h9999_AA7C;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] PRIM_X_RDY = 32'h5757_B57C;
    localparam logic [31:0] PRIM_R_RDY = 32'h4A4A_957C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRIM = 2'd1,
        ST_CONT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/satalnk_alignwd.sv
// Saturating ALIGN watchdog: counts non-ALIGN words, reports loss of cadence
// while pinned at 2^LGALIGN-1. A clear always beats a count in the same cycle.
module satalnk_alignwd #(
    parameter int LGALIGN = 8
) (
    input  logic i_rx_clk,
    input  logic i_reset,
    input  logic count_i,
    input  logic clear_i,
    output logic lost_o
);

    localparam logic [LGALIGN-1:0] WD_MAX = '1;

    logic [LGALIGN-1:0] count_q, count_d;

    // NOTE: every path assigns count_d via the default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i && (count_q != WD_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_rx_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign lost_o = (count_q == WD_MAX);

endmodule

// File: rtl/satalnk_rxprim.sv
// SATA RX primitive filter: strips ALIGN, resolves CONT runs (expand or drop),
// flags CONT errors and ALIGN loss. Optional stats ports: SATALNK_RXPRIM_STATS_EN.
module satalnk_rxprim
    import satalnk_rxprim_pkg::*;
#(
    parameter int          OPT_EXPAND = 1,
    parameter int          LGALIGN    = 8,
    parameter logic [31:0] P_ALIGN    = PRIM_ALIGN,
    parameter logic [31:0] P_CONT     = PRIM_CONT
) (
    input  logic        i_rx_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_primitive,
    input  logic [31:0] i_data,
    output logic        o_valid,
    output logic        o_primitive,
    output logic [31:0] o_data,
    output logic        o_cont_err,
    output logic        o_align_lost
`ifdef SATALNK_RXPRIM_STATS_EN
    ,
    output logic [15:0] o_align_count,
    output logic [15:0] o_cont_count
`endif
);

    logic        is_align, is_cont;
    rx_state_e   state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        prim_q, prim_d;
    logic        err_q, err_d;
    logic        wd_count, wd_clear;

    assign is_align = i_primitive && (i_data == P_ALIGN);
    assign is_cont  = i_primitive && (i_data == P_CONT);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = 1'b0;
        prim_d  = 1'b0;
        err_d   = 1'b0;
        // ALIGN words fall through untouched: no output, no state change.
        if (i_valid && !is_align) begin
            if (is_cont) begin
                if (state_q == ST_PRIM) begin
                    state_d = ST_CONT;
                end else if (state_q == ST_IDLE) begin
                    err_d = 1'b1;
                end
            end else if (i_primitive) begin
                valid_d = 1'b1;
                prim_d  = 1'b1;
                data_d  = i_data;
                hold_d  = i_data;
                state_d = ST_PRIM;
            end else if (state_q == ST_CONT) begin
                // Scrambled filler: replay the held primitive or swallow it.
                if (OPT_EXPAND != 0) begin
                    valid_d = 1'b1;
                    prim_d  = 1'b1;
                    data_d  = hold_q;
                end
            end else begin
                valid_d = 1'b1;
                data_d  = i_data;
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: the hold register is plain state, so it gets an explicit reset value too.
    always_ff @(posedge i_rx_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            prim_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            prim_q  <= prim_d;
            err_q   <= err_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_primitive = prim_q;
    assign o_data      = data_q;
    assign o_cont_err  = err_q;

    assign wd_count = i_valid && !is_align;
    assign wd_clear = i_valid && is_align;

    satalnk_alignwd #(
        .LGALIGN(LGALIGN)
    ) u_alignwd (
        .i_rx_clk(i_rx_clk),
        .i_reset (i_reset),
        .count_i (wd_count),
        .clear_i (wd_clear),
        .lost_o  (o_align_lost)
    );

`ifdef SATALNK_RXPRIM_STATS_EN
    logic        align_inc, cont_inc;
    logic [15:0] align_cnt_q, cont_cnt_q;

    assign align_inc = i_valid && is_align;
    assign cont_inc  = i_valid && is_cont && (state_q == ST_PRIM);

    always_ff @(posedge i_rx_clk or posedge i_reset) begin
        if (i_reset) begin
            align_cnt_q <= '0;
            cont_cnt_q  <= '0;
        end else begin
            if (align_inc && (align_cnt_q != 16'hFFFF)) begin
                align_cnt_q <= align_cnt_q + 16'd1;
            end
            if (cont_inc && (cont_cnt_q != 16'hFFFF)) begin
                cont_cnt_q <= cont_cnt_q + 16'd1;
            end
        end
    end

    assign o_align_count = align_cnt_q;
    assign o_cont_count  = cont_cnt_q;
`endif

endmodule

// File: tb/tb_satalnk_rxprim.sv
// Scoreboard bench: one expanding and one dropping filter share the stimulus;
// expected words are queued per instance and popped by monitors on o_valid.
module tb_satalnk_rxprim;
    import satalnk_rxprim_pkg::*;

    typedef struct {
        logic        prim;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        i_rx_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_primitive;
    logic [31:0] i_data;

    logic        e_valid, e_prim, e_err, e_lost;
    logic [31:0] e_data;
    logic        d_valid, d_prim, d_err, d_lost;
    logic [31:0] d_data;
`ifdef SATALNK_RXPRIM_STATS_EN
    logic [15:0] e_acnt, e_ccnt, d_acnt, d_ccnt;
`endif

    exp_t q_e[$];
    exp_t q_d[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   err_e = 0;
    int   err_d = 0;
    int   n_e = 0;
    int   n_d = 0;

    always #5 i_rx_clk = ~i_rx_clk;
    always @(posedge i_rx_clk) cyc <= cyc + 1;

    satalnk_rxprim #(.OPT_EXPAND(1), .LGALIGN(4)) dut_e (
        .i_rx_clk    (i_rx_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_primitive (i_primitive),
        .i_data      (i_data),
        .o_valid     (e_valid),
        .o_primitive (e_prim),
        .o_data      (e_data),
        .o_cont_err  (e_err),
        .o_align_lost(e_lost)
`ifdef SATALNK_RXPRIM_STATS_EN
        ,
        .o_align_count(e_acnt),
        .o_cont_count (e_ccnt)
`endif
    );

    satalnk_rxprim #(.OPT_EXPAND(0), .LGALIGN(4)) dut_d (
        .i_rx_clk    (i_rx_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_primitive (i_primitive),
        .i_data      (i_data),
        .o_valid     (d_valid),
        .o_primitive (d_prim),
        .o_data      (d_data),
        .o_cont_err  (d_err),
        .o_align_lost(d_lost)
`ifdef SATALNK_RXPRIM_STATS_EN
        ,
        .o_align_count(d_acnt),
        .o_cont_count (d_ccnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one valid word; ev/dv say whether each instance must emit (ep, ed) next cycle.
    task automatic word(input logic k, input logic [31:0] w, input logic ev, input logic dv,
                        input logic [31:0] ed, input logic ep);
        exp_t x;
        @(negedge i_rx_clk);
        i_valid     = 1'b1;
        i_primitive = k;
        i_data      = w;
        x.prim = ep;
        x.data = ed;
        x.cyc  = cyc + 1;
        if (ev) q_e.push_back(x);
        if (dv) q_d.push_back(x);
    endtask

    task automatic idle();
        @(negedge i_rx_clk);
        i_valid     = 1'b0;
        i_primitive = 1'b0;
        i_data      = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {e_valid, d_valid}, 0);
        check({tag, "_prim"}, {e_prim, d_prim}, 0);
        check({tag, "_data_e"}, e_data, 0);
        check({tag, "_data_d"}, d_data, 0);
        check({tag, "_err"}, {e_err, d_err}, 0);
        check({tag, "_lost"}, {e_lost, d_lost}, 0);
    endtask

    task automatic do_reset();
        @(negedge i_rx_clk);
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        check_zero("rst_async");
        @(negedge i_rx_clk);
        i_reset = 1'b0;
    endtask

    always @(negedge i_rx_clk) begin
        exp_t x;
        if (e_valid === 1'b1) begin
            n_e++;
            if (q_e.size() == 0) begin
                check("e_unexpected_out", e_data, 32'hDEAD_BEEF);
            end else begin
                x = q_e.pop_front();
                check("e_prim", e_prim, x.prim);
                check("e_data", e_data, x.data);
                check("e_latency", cyc, x.cyc);
            end
        end
        if (e_err === 1'b1) err_e++;
    end

    always @(negedge i_rx_clk) begin
        exp_t x;
        if (d_valid === 1'b1) begin
            n_d++;
            if (q_d.size() == 0) begin
                check("d_unexpected_out", d_data, 32'hDEAD_BEEF);
            end else begin
                x = q_d.pop_front();
                check("d_prim", d_prim, x.prim);
                check("d_data", d_data, x.data);
                check("d_latency", cyc, x.cyc);
            end
        end
        if (d_err === 1'b1) err_d++;
    end

    initial begin
        int ne0, nd0;
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_primitive = 1'b0;
        i_data      = '0;
        @(negedge i_rx_clk);
        @(negedge i_rx_clk);
        check_zero("reset");
`ifdef SATALNK_RXPRIM_STATS_EN
        check("reset_counts", {e_acnt, e_ccnt}, 0);
`endif
        i_reset = 1'b0;

        // X_RDY, CONT, 5 filler words, SYNC
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        word(1, PRIM_X_RDY, 1, 1, PRIM_X_RDY, 1);
        word(1, PRIM_CONT, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) word(0, 32'hC0DE_0000 + i, 1, 0, PRIM_X_RDY, 1);
        word(1, PRIM_SYNC, 1, 1, PRIM_SYNC, 1);
        idle();
        idle();
        check("cont_run_drained", q_e.size() + q_d.size(), 0);
`ifdef SATALNK_RXPRIM_STATS_EN
        check("cont_count_e", e_ccnt, 1);
        check("cont_count_d", d_ccnt, 1);
        check("align_count_e", e_acnt, 1);
`endif

        // Watchdog with LGALIGN=4: saturates at 15 words.
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) word(0, 32'h0000_A000 + i, 1, 1, 32'h0000_A000 + i, 0);
        idle();
        check("lost_at_14", {e_lost, d_lost}, 2'b00);
        word(0, 32'h0000_A0FF, 1, 1, 32'h0000_A0FF, 0);
        idle();
        check("lost_at_15", {e_lost, d_lost}, 2'b11);
        idle();
        check("lost_held", {e_lost, d_lost}, 2'b11);
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        idle();
        check("lost_cleared", {e_lost, d_lost}, 2'b00);
        for (int i = 0; i < 14; i++) word(0, 32'h0000_B000 + i, 1, 1, 32'h0000_B000 + i, 0);
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        idle();
        check("lost_clear_wins", {e_lost, d_lost}, 2'b00);
        idle();
        check("lost_clear_wins2", {e_lost, d_lost}, 2'b00);
`ifdef SATALNK_RXPRIM_STATS_EN
        check("align_count_wd", e_acnt, 4);
`endif

        // Reset, then CONT with nothing held.
        do_reset();
`ifdef SATALNK_RXPRIM_STATS_EN
        check("counts_after_rst", {d_acnt, d_ccnt}, 0);
`endif
        word(1, PRIM_CONT, 0, 0, 0, 0);
        idle();
        check("cont_err_pulse", {e_err, d_err}, 2'b11);
        idle();
        check("cont_err_one_cycle", {e_err, d_err}, 2'b00);
        word(0, PRIM_CONT, 1, 1, PRIM_CONT, 0);
        idle();
        idle();

        // Gaps, ALIGNs and a repeated CONT inside a CONT run.
        ne0 = n_e;
        nd0 = n_d;
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        word(1, PRIM_HOLD, 1, 1, PRIM_HOLD, 1);
        word(1, PRIM_CONT, 0, 0, 0, 0);
        word(0, 32'h1111_0001, 1, 0, PRIM_HOLD, 1);
        idle();
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        word(0, 32'h1111_0002, 1, 0, PRIM_HOLD, 1);
        word(1, PRIM_CONT, 0, 0, 0, 0);
        idle();
        idle();
        word(0, 32'h1111_0003, 1, 0, PRIM_HOLD, 1);
        word(1, PRIM_ALIGN, 0, 0, 0, 0);
        word(0, 32'h1111_0004, 1, 0, PRIM_HOLD, 1);
        word(1, PRIM_R_RDY, 1, 1, PRIM_R_RDY, 1);
        idle();
        idle();
        check("gap_outputs_e", n_e - ne0, 6);
        check("gap_outputs_d", n_d - nd0, 2);
`ifdef SATALNK_RXPRIM_STATS_EN
        check("gap_cont_count", e_ccnt, 1);
        check("gap_align_count", e_acnt, 3);
`endif

        // Reset while CONT is active, then plain data.
        word(1, PRIM_SYNC, 1, 1, PRIM_SYNC, 1);
        word(1, PRIM_CONT, 0, 0, 0, 0);
        word(0, 32'h2222_0001, 1, 0, PRIM_SYNC, 1);
        idle();
        do_reset();
        word(0, 32'h1234_5678, 1, 1, 32'h1234_5678, 0);
        idle();
        idle();

        check("final_queue_e", q_e.size(), 0);
        check("final_queue_d", q_d.size(), 0);
        check("cont_err_total_e", err_e, 1);
        check("cont_err_total_d", err_d, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
